// File: rtl/sna_response_tx_vc.sv
// AXI4-Lite read/write response to NoC packetizer: captures one response,
// claims a free virtual channel and emits a header/[body]/tail flit sequence.
module sna_response_tx_vc #(
    parameter int DATA_W = 32,
    parameter int FLIT_W = DATA_W + 5,
    parameter int NUM_VC = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [FLIT_W-1:0] header,
    input  logic [FLIT_W-1:0] tail,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              rready,
    input  logic              bvalid,
    input  logic [1:0]        bresp,
    output logic              bready,
    input  logic [NUM_VC-1:0] is_allocatable,
    input  logic [NUM_VC-1:0] is_on_off,
    output logic [FLIT_W-1:0] noc_data,
    output logic              is_valid,
    output logic [NUM_VC-1:0] vc_sel,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for a read or write response; ready may be granted
    // ALLOC | response captured, searching for a free VC with credit
    // HEAD  | presenting the header flit
    // BODY  | presenting the read-data flit (read packets only)
    // TAIL  | presenting the tail flit carrying the response code
    typedef enum logic [2:0] {IDLE, ALLOC, HEAD, BODY, TAIL} state_t;

    state_t              state;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          resp_q;
    logic                is_read_q;
    logic                last_b;
    logic                grant_r;
    logic                grant_b;
    logic [NUM_VC-1:0]   cand;
    logic [NUM_VC-1:0]   pick;
    logic                sel_on;
    logic [FLIT_W-1:0]   tail_flit;

    // Round-robin: with both valid, the channel not served last wins.
    always_comb begin
        grant_r = rvalid && (!bvalid || last_b);
        grant_b = bvalid && !grant_r;
        rready  = (state == IDLE) && grant_r && !reset;
        bready  = (state == IDLE) && grant_b && !reset;
    end

    always_comb begin
        cand = is_allocatable & is_on_off;
        pick = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_on   = |(is_on_off & vc_sel);
        busy     = (state != IDLE);
        is_valid = ((state == HEAD) || (state == BODY) || (state == TAIL)) && sel_on;
        tail_flit = tail;
        tail_flit[DATA_W+1:DATA_W] = resp_q;
        case (state)
            HEAD:    noc_data = header;
            BODY:    noc_data = FLIT_W'({3'b000, resp_q, data_q});
            TAIL:    noc_data = tail_flit;
            default: noc_data = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            data_q    <= '0;
            resp_q    <= '0;
            is_read_q <= 1'b0;
            last_b    <= 1'b1;
            vc_sel    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_r) begin
                        data_q    <= rdata;
                        resp_q    <= rresp;
                        is_read_q <= 1'b1;
                        last_b    <= 1'b0;
                        state     <= ALLOC;
                    end else if (grant_b) begin
                        data_q    <= '0;
                        resp_q    <= bresp;
                        is_read_q <= 1'b0;
                        last_b    <= 1'b1;
                        state     <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (|pick) begin
                        vc_sel <= pick;
                        state  <= HEAD;
                    end
                end
                HEAD: begin
                    if (is_valid) state <= is_read_q ? BODY : TAIL;
                end
                BODY: begin
                    if (is_valid) state <= TAIL;
                end
                TAIL: begin
                    if (is_valid) begin
                        vc_sel <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sna_response_tx_vc.sv
// Directed bench for sna_response_tx_vc: table of single-packet scenarios
// plus hand sequences for arbitration and reset during a packet.
module tb_sna_response_tx_vc;

    localparam int DATA_W = 32;
    localparam int FLIT_W = 37;
    localparam int NUM_VC = 8;
    localparam logic [FLIT_W-1:0] HDR = 37'h0A_0000_1234;
    localparam logic [FLIT_W-1:0] TLR = 37'h1F_CAFE_0001;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [FLIT_W-1:0] header = HDR;
    logic [FLIT_W-1:0] tail = TLR;
    logic              rvalid = 1'b0;
    logic [DATA_W-1:0] rdata = '0;
    logic [1:0]        rresp = '0;
    logic              rready;
    logic              bvalid = 1'b0;
    logic [1:0]        bresp = '0;
    logic              bready;
    logic [NUM_VC-1:0] is_allocatable = '0;
    logic [NUM_VC-1:0] is_on_off = '0;
    logic [FLIT_W-1:0] noc_data;
    logic              is_valid;
    logic [NUM_VC-1:0] vc_sel;
    logic              busy;

    int checks = 0;
    int errors = 0;

    sna_response_tx_vc #(.DATA_W(DATA_W), .FLIT_W(FLIT_W), .NUM_VC(NUM_VC)) dut (
        .clock(clock), .reset(reset), .header(header), .tail(tail),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .is_allocatable(is_allocatable), .is_on_off(is_on_off),
        .noc_data(noc_data), .is_valid(is_valid), .vc_sel(vc_sel), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic                   is_read;
        logic [DATA_W-1:0]      data;
        logic [1:0]             resp;
        logic [NUM_VC-1:0]      alloc;
        logic [NUM_VC-1:0]      on;
        int                     alloc_delay;
        int                     drop_start;
        int                     drop_len;
        logic [NUM_VC-1:0]      exp_vc;
        int                     exp_n;
        logic [2:0][FLIT_W-1:0] exp_flit;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(logic rd, logic [31:0] d, logic [1:0] rs, logic [7:0] al,
                                logic [7:0] on, int ad, int ds, int dl, logic [7:0] ev,
                                int n, logic [36:0] f0, logic [36:0] f1, logic [36:0] f2);
        vec_t v;
        v.is_read = rd; v.data = d; v.resp = rs; v.alloc = al; v.on = on;
        v.alloc_delay = ad; v.drop_start = ds; v.drop_len = dl; v.exp_vc = ev;
        v.exp_n = n; v.exp_flit[0] = f0; v.exp_flit[1] = f1; v.exp_flit[2] = f2;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clock);
        reset = 1'b1; rvalid = 1'b0; bvalid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("reset_outputs", {noc_data, is_valid, vc_sel, busy, rready, bready}, 64'h0);
        reset = 1'b0;
    endtask

    task automatic run_vec(input int id);
        vec_t v;
        logic [2:0][FLIT_W-1:0] got;
        logic [NUM_VC-1:0] vc_got;
        int n, first, pre_err, stall_err, stall_cnt, rel;
        bit done;
        v = vecs[id];
        got = '0; vc_got = '0; n = 0; first = -1;
        pre_err = 0; stall_err = 0; stall_cnt = 0; done = 0;
        @(negedge clock);
        rvalid = v.is_read; bvalid = !v.is_read;
        rdata = v.data; rresp = v.resp; bresp = v.resp;
        is_allocatable = '0; is_on_off = v.on;
        #1;
        check($sformatf("v%0d_ready", id), {rready, bready}, v.is_read ? 2'b10 : 2'b01);
        check($sformatf("v%0d_idle_busy", id), busy, 1'b0);
        @(negedge clock);
        rvalid = 1'b0; bvalid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            is_allocatable = (k < v.alloc_delay) ? '0 : v.alloc;
            rel = k - first;
            if (first >= 0 && v.drop_len > 0 && rel >= v.drop_start && rel < v.drop_start + v.drop_len)
                is_on_off = '0;
            else
                is_on_off = v.on;
            #1;
            if (is_valid) begin
                if (n == 0) begin
                    first = k;
                    vc_got = vc_sel;
                end
                if (n < 3) got[n] = noc_data;
                n++;
            end else if (busy && n == 0) begin
                if (noc_data !== '0 || vc_sel !== '0) pre_err++;
            end else if (busy) begin
                stall_cnt++;
                if (n < 3 && noc_data !== v.exp_flit[n]) stall_err++;
            end
            if (!busy && n > 0) begin
                done = 1;
                break;
            end
            @(negedge clock);
        end
        check($sformatf("v%0d_completed", id), done, 1'b1);
        check($sformatf("v%0d_nflits", id), n, v.exp_n);
        for (int i = 0; i < v.exp_n; i++)
            check($sformatf("v%0d_flit%0d", id, i), got[i], v.exp_flit[i]);
        check($sformatf("v%0d_vc_sel", id), vc_got, v.exp_vc);
        check($sformatf("v%0d_first_flit_cycle", id), first, v.alloc_delay + 1);
        check($sformatf("v%0d_alloc_outputs", id), pre_err, 0);
        check($sformatf("v%0d_stall_cycles", id), stall_cnt, v.drop_len);
        check($sformatf("v%0d_stall_data", id), stall_err, 0);
    endtask

    initial begin
        bit grants [$];
        int both_err, busy_err;
        bit idle_seen;

        //             rd  data          rs     alloc  on     ad ds dl vc     n  flits
        vecs[0] = mk(1, 32'hDEADBEEF, 2'd0, 8'h01, 8'h01, 0, 0, 0, 8'h01, 3,
                     HDR, 37'h00_DEAD_BEEF, 37'h1C_CAFE_0001);
        vecs[1] = mk(0, 32'h0,        2'd2, 8'h04, 8'h04, 0, 0, 0, 8'h04, 2,
                     HDR, 37'h1E_CAFE_0001, 37'h0);
        vecs[2] = mk(1, 32'h12345678, 2'd1, 8'h0C, 8'h08, 0, 1, 3, 8'h08, 3,
                     HDR, 37'h01_1234_5678, 37'h1D_CAFE_0001);
        vecs[3] = mk(0, 32'h0,        2'd3, 8'h80, 8'hFF, 5, 0, 0, 8'h80, 2,
                     HDR, 37'h1F_CAFE_0001, 37'h0);
        vecs[4] = mk(0, 32'h0,        2'd1, 8'h30, 8'h20, 0, 1, 2, 8'h20, 2,
                     HDR, 37'h1D_CAFE_0001, 37'h0);
        vecs[5] = mk(1, 32'hA5A5A5A5, 2'd2, 8'h80, 8'hFF, 5, 0, 0, 8'h80, 3,
                     HDR, 37'h02_A5A5_A5A5, 37'h1E_CAFE_0001);

        reset_dut();
        for (int i = 0; i < 6; i++) run_vec(i);

        // Both channels held valid: grants must alternate R, B, R, B from reset.
        reset_dut();
        @(negedge clock);
        rvalid = 1'b1; bvalid = 1'b1; rdata = 32'h0BADF00D; rresp = 2'd1; bresp = 2'd2;
        is_allocatable = 8'hFF; is_on_off = 8'hFF;
        both_err = 0; busy_err = 0;
        for (int k = 0; k < 60 && grants.size() < 4; k++) begin
            #1;
            if (rready && bready) both_err++;
            if ((rready || bready) && busy) busy_err++;
            if (rready) grants.push_back(1'b0);
            if (bready) grants.push_back(1'b1);
            @(negedge clock);
        end
        rvalid = 1'b0; bvalid = 1'b0;
        check("rr_grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("rr_grant%0d", i), grants[i], (i % 2 == 1) ? 1'b1 : 1'b0);
        check("rr_both_ready", both_err, 0);
        check("rr_ready_while_busy", busy_err, 0);
        idle_seen = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (!busy) begin
                idle_seen = 1;
                break;
            end
            @(negedge clock);
        end
        check("rr_drain", idle_seen, 1'b1);

        // Reset asserted while the header flit is on the wire.
        reset_dut();
        @(negedge clock);
        rvalid = 1'b1; rdata = 32'h11112222; rresp = 2'd0;
        is_allocatable = 8'h01; is_on_off = 8'h01;
        @(negedge clock);
        rvalid = 1'b0;
        @(negedge clock);
        #1;
        check("rst_head_valid", {is_valid, noc_data}, {1'b1, HDR});
        reset = 1'b1; rvalid = 1'b1;
        #1;
        check("rst_outputs_zero", {noc_data, is_valid, vc_sel, busy, rready}, 64'h0);
        @(negedge clock);
        reset = 1'b0; rvalid = 1'b0;
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
